fetch_cycle: RTL and testbench
==============================

FETCH_CYCLE -- requirements
Module: fetch_cycle

Interface
REQ-001 The block SHALL have ports: clk (in, 1, sole clock); rst (in, 1, asynchronous active-low reset).
REQ-002 The block SHALL have ports: PCSrcE (in, 1, redirect request from execute); PCTargetE (in, 32, redirect target).
REQ-003 The block SHALL have ports: StallD (in, 1, decode cannot accept); FlushD (in, 1, kill IF/ID contents).
REQ-004 The block SHALL have ports: imem_req (out, 1, one-cycle fetch request pulse); imem_addr (out, 32, fetch address).
REQ-005 The block SHALL have ports: imem_valid (in, 1, response strobe); imem_rdata (in, 32, fetched word).
REQ-006 The block SHALL have outputs: InstrD (32), PCD (32), PCPlus4D (32), ValidD (1, InstrD is a real instruction); all are registered.

Function
REQ-007 PCF (internal, 32 bits) SHALL load RESET_PC on reset and advance by 4 with modulo-2^32 wrap; bits [1:0] SHALL always be 00.
REQ-008 FSM states SHALL be S_ISSUE, S_WAIT and S_HOLD; reset state SHALL be S_ISSUE.
REQ-009 In S_ISSUE, imem_req SHALL be 1 for exactly one cycle with imem_addr=PCF, and the next state SHALL be S_WAIT.
REQ-010 In S_WAIT with imem_valid=1 and StallD=0, IF/ID SHALL load InstrD=imem_rdata, PCD=PCF, PCPlus4D=PCF+4, ValidD=1; PCF SHALL become PCF+4; the next state SHALL be S_ISSUE.
REQ-011 In S_WAIT with imem_valid=1 and StallD=1, the word SHALL be captured in a one-entry hold buffer and the next state SHALL be S_HOLD.
REQ-012 In S_HOLD, the block SHALL wait while StallD=1; when StallD falls, it SHALL transfer the hold buffer to IF/ID per REQ-010 and go to S_ISSUE.
REQ-013 Minimum throughput SHALL be one instruction per 2 cycles for a 1-cycle-latency memory; imem_valid in any state other than S_WAIT SHALL be ignored.
REQ-014 PCSrcE=1 SHALL have top priority in every state:
- PCF SHALL load {PCTargetE[31:2],2'b00}.
- From S_HOLD, the hold buffer SHALL be discarded and the next state SHALL be S_ISSUE.
- From S_WAIT, a squash flag SHALL be set; the next response SHALL be dropped, then the state SHALL go to S_ISSUE.
- From S_ISSUE, the just-issued request SHALL be squashed.
REQ-015 FlushD=1 SHALL load InstrD=NOP_INSTR and ValidD=0 on the next edge, overriding StallD and any delivery in that cycle.
REQ-016 With StallD=1 and FlushD=0, IF/ID SHALL hold its value; with StallD=0 and no delivery, ValidD SHALL become 0 (bubble).
REQ-017 A squashed response SHALL never reach IF/ID or advance PCF.

Reset
REQ-018 While rst=0 (asynchronous, active-low): PCF=RESET_PC; state=S_ISSUE; squash=0; hold buffer empty; InstrD=NOP_INSTR; PCD=0; PCPlus4D=0; ValidD=0; imem_req=0; imem_addr=RESET_PC.
REQ-019 Reset asserted mid-request SHALL abandon the outstanding fetch; the first request after release SHALL occur on the first clk edge and SHALL use RESET_PC.

Configuration
REQ-020 Macro FETCH_PERF_CNT_EN defined: outputs FetchCount (32, increments per ValidD=1 load) and StallCount (32, increments per cycle in S_HOLD) SHALL exist, both reset to 0 and wrapping. Undefined: these ports and their counters SHALL be absent, with otherwise identical behaviour.

Structure
REQ-021 Package cpu_pkg SHALL hold RESET_PC (32'h0000_0000), NOP_INSTR (32'h0000_0000) and the fetch_state_t enum.
REQ-022 The hold buffer SHALL be a sub-module fetch_hold_buf (one-entry register with load/clear/full); all other logic SHALL be flat.

Verification
REQ-023 Reset release, 1-cycle memory returning 0x11111111, 0x22222222 -> imem_addr 0x0 then 0x4; InstrD/PCD sequence (0x11111111,0x0), (0x22222222,0x4); PCPlus4D=0x4, 0x8.
REQ-024 StallD=1 for 3 cycles when the word 0xAAAA0000 at PC 0x8 returns -> state S_HOLD; IF/ID unchanged; after release InstrD=0xAAAA0000, PCD=0x8, next imem_addr=0xC.
REQ-025 PCSrcE=1 with PCTargetE=0x103 while in S_WAIT -> that response dropped; next imem_addr=0x100; the dropped word never appears with ValidD=1.
REQ-026 FlushD=1 and StallD=1 together -> InstrD=0x00000000 and ValidD=0 on the next edge.
REQ-027 Redirect to 0xFFFFFFFC then a sequential fetch -> imem_addr=0xFFFFFFFC then 0x00000000.
REQ-028 rst=0 pulse while in S_WAIT -> all outputs at reset values; after release imem_addr=0x0; with FETCH_PERF_CNT_EN defined, FetchCount=0 and StallCount=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared constants and types for the instruction fetch stage.
//   RESET_PC      : address of the first fetch after reset
//   NOP_INSTR     : word placed in InstrD when IF/ID is flushed or reset
//   fetch_state_t : fetch FSM states (S_ISSUE, S_WAIT, S_HOLD)
package cpu_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf -- one-entry buffer that parks a fetched word while decode
// is stalled.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset (buffer empties)
//   i_load     : capture i_data and mark the entry full
//   i_clear    : mark the entry empty (clear wins over load)
//   i_data     : word to capture
//   o_data     : parked word
//   o_full     : entry holds a valid word
module fetch_hold_buf
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_full
);

  logic [31:0] r_data;
  logic        r_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= NOP_INSTR;
      r_full <= 1'b0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_data <= i_data;
      r_full <= 1'b1;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/fetch_cycle.sv
// fetch_cycle -- instruction fetch stage with a single-outstanding request
// memory interface and the IF/ID pipeline register.
// Ports:
//   clk, rst             : clock, asynchronous active-low reset
//   PCSrcE, PCTargetE    : redirect request and target from execute
//   StallD, FlushD       : decode stall / IF/ID kill
//   imem_req, imem_addr  : one-cycle request pulse and fetch address (registered)
//   imem_valid, imem_rdata : response strobe and fetched word
//   InstrD, PCD, PCPlus4D, ValidD : IF/ID register contents
//   FetchCount, StallCount : performance counters, present only when the
//                          macro FETCH_PERF_CNT_EN is defined
module fetch_cycle
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  input  logic        FlushD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
`ifdef FETCH_PERF_CNT_EN
  output logic        ValidD,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
`else
  output logic        ValidD
`endif
);

  fetch_state_t r_state;
  logic [31:0]  r_pcf;
  logic         r_squash;
  logic         r_imem_req;
  logic [31:0]  r_imem_addr;
  logic [31:0]  r_instr_d;
  logic [31:0]  r_pc_d;
  logic [31:0]  r_pc_plus4_d;
  logic         r_valid_d;

  logic [31:0]  w_redirect_pc;
  logic [31:0]  w_pcf_plus4;
  logic         w_live_resp;
  logic         w_from_wait;
  logic         w_from_hold;
  logic         w_deliver;
  logic [31:0]  w_deliver_word;
  logic         w_hold_load;
  logic         w_hold_clear;
  logic [31:0]  w_hold_data;
  logic         w_hold_full;

  // Masking (rather than slicing) keeps the target word-aligned.
  assign w_redirect_pc = PCTargetE & ~32'd3;
  assign w_pcf_plus4   = r_pcf + 32'd4;

  // A response only counts in S_WAIT, and a redirect in the same cycle
  // kills it just like a pending squash does.
  assign w_live_resp = (r_state == S_WAIT) && imem_valid && !r_squash && !PCSrcE;
  assign w_from_wait = w_live_resp && !StallD;
  assign w_from_hold = (r_state == S_HOLD) && w_hold_full && !PCSrcE && !StallD;
  assign w_deliver   = w_from_wait || w_from_hold;
  assign w_deliver_word = w_from_hold ? w_hold_data : imem_rdata;

  assign w_hold_load  = w_live_resp && StallD;
  assign w_hold_clear = (r_state == S_HOLD) && (PCSrcE || !StallD);

  fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_hold_load),
    .i_clear (w_hold_clear),
    .i_data  (imem_rdata),
    .o_data  (w_hold_data),
    .o_full  (w_hold_full)
  );

  // Fetch FSM, PC and memory-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_ISSUE;
      r_pcf       <= RESET_PC;
      r_squash    <= 1'b0;
      r_imem_req  <= 1'b0;
      r_imem_addr <= RESET_PC;
    end else begin
      r_imem_req <= 1'b0;
      case (r_state)
        S_ISSUE: begin
          r_imem_req  <= 1'b1;
          r_imem_addr <= r_pcf;
          r_state     <= S_WAIT;
          // A redirect while issuing makes this request stale.
          r_squash    <= PCSrcE;
        end
        S_WAIT: begin
          if (imem_valid) begin
            r_squash <= 1'b0;
            if (r_squash || PCSrcE) begin
              r_state <= S_ISSUE;
            end else if (StallD) begin
              r_state <= S_HOLD;
            end else begin
              r_state <= S_ISSUE;
            end
          end else if (PCSrcE) begin
            r_squash <= 1'b1;
          end
        end
        S_HOLD: begin
          if (PCSrcE || !StallD) begin
            r_state <= S_ISSUE;
          end
        end
        default: r_state <= S_ISSUE;
      endcase

      if (PCSrcE) begin
        r_pcf <= w_redirect_pc;
      end else if (w_deliver) begin
        r_pcf <= w_pcf_plus4;
      end
    end
  end

  // IF/ID register: flush beats stall, stall holds, otherwise a bubble
  // unless a word is delivered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= 32'd0;
      r_pc_plus4_d <= 32'd0;
      r_valid_d    <= 1'b0;
    end else if (FlushD) begin
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end else if (!StallD) begin
      if (w_deliver) begin
        r_instr_d    <= w_deliver_word;
        r_pc_d       <= r_pcf;
        r_pc_plus4_d <= w_pcf_plus4;
        r_valid_d    <= 1'b1;
      end else begin
        r_valid_d <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (w_deliver && !FlushD) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (r_state == S_HOLD) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign FetchCount = r_fetch_cnt;
  assign StallCount = r_stall_cnt;
`endif

  assign imem_req  = r_imem_req;
  assign imem_addr = r_imem_addr;
  assign InstrD    = r_instr_d;
  assign PCD       = r_pc_d;
  assign PCPlus4D  = r_pc_plus4_d;
  assign ValidD    = r_valid_d;

endmodule

// File: tb/tb_fetch_cycle.sv
// tb_fetch_cycle -- directed vector table plus randomized run of fetch_cycle
// against a transaction-level reference model and a simple memory model.
module tb_fetch_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallD;
  logic        FlushD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCount;
  logic [31:0] StallCount;
`endif

  fetch_cycle dut (
    .clk        (clk),
    .rst        (rst),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
`ifdef FETCH_PERF_CNT_EN
    .ValidD     (ValidD),
    .FetchCount (FetchCount),
    .StallCount (StallCount)
`else
    .ValidD     (ValidD)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- memory model ----------------
  bit          mem_pend = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h1111_1111;
      32'h0000_0004: return 32'h2222_2222;
      32'h0000_0008: return 32'hAAAA_0000;
      32'h0000_000C: return 32'h3333_3333;
      32'h0000_0010: return 32'hDEAD_BEEF;
      32'h0000_0100: return 32'h4444_4444;
      32'h0000_0104: return 32'h5555_5555;
      32'hFFFF_FFFC: return 32'h6666_6666;
      default:       return {a[15:0], ~a[31:16]};
    endcase
  endfunction

  // ---------------- reference model ----------------
  // Tracks: is a request outstanding, is its answer to be thrown away,
  // is a word parked for decode, and what IF/ID should show.
  logic [31:0] m_pc;
  bit          m_out, m_drop, m_parked;
  logic [31:0] m_park_word;
  logic        m_req, m_vld;
  logic [31:0] m_addr, m_instr, m_pcd, m_pc4, m_fcnt, m_scnt;

  task automatic model_reset();
    m_pc = 32'd0; m_out = 0; m_drop = 0; m_parked = 0; m_park_word = 32'd0;
    m_req = 0; m_vld = 0; m_addr = 32'd0; m_instr = 32'd0; m_pcd = 32'd0;
    m_pc4 = 32'd0; m_fcnt = 32'd0; m_scnt = 32'd0;
  endtask

  task automatic model_step(input logic pcsrc, input logic [31:0] tgt, input logic stall,
                            input logic flush, input logic v, input logic [31:0] rd);
    bit          idle = !m_out && !m_parked;
    bit          was_out = m_out;
    bit          was_parked = m_parked;
    bit          got = 0;
    logic [31:0] word = 32'd0;
    logic [31:0] fetch_pc = m_pc;
    m_req = idle;
    if (idle) begin
      m_addr = m_pc;
      m_out  = 1;
      m_drop = pcsrc;
    end
    if (was_out) begin
      if (v) begin
        if (!m_drop && !pcsrc) begin
          if (stall) begin m_parked = 1; m_park_word = rd; end
          else begin got = 1; word = rd; end
        end
        m_out = 0; m_drop = 0;
      end else if (pcsrc) begin
        m_drop = 1;
      end
    end
    if (was_parked) begin
      m_scnt = m_scnt + 1;
      if (pcsrc) m_parked = 0;
      else if (!stall) begin got = 1; word = m_park_word; m_parked = 0; end
    end
    if (pcsrc) m_pc = {tgt[31:2], 2'b00};
    else if (got) m_pc = m_pc + 32'd4;
    if (flush) begin
      m_instr = 32'd0; m_vld = 0;
    end else if (!stall) begin
      if (got) begin
        m_instr = word; m_pcd = fetch_pc; m_pc4 = fetch_pc + 32'd4; m_vld = 1;
        m_fcnt = m_fcnt + 1;
      end else begin
        m_vld = 0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req}, {31'd0, m_req});
    chk({tag, "_addr"},  imem_addr, m_addr);
    chk({tag, "_instr"}, InstrD, m_instr);
    chk({tag, "_pcd"},   PCD, m_pcd);
    chk({tag, "_pc4"},   PCPlus4D, m_pc4);
    chk({tag, "_vld"},   {31'd0, ValidD}, {31'd0, m_vld});
`ifdef FETCH_PERF_CNT_EN
    chk({tag, "_fcnt"},  FetchCount, m_fcnt);
    chk({tag, "_scnt"},  StallCount, m_scnt);
`endif
  endtask

  // One clock: present memory response, drive inputs, advance the model,
  // clock, then update the memory model from the request just observed.
  task automatic cycle(input logic pcsrc, input logic [31:0] tgt, input logic stall,
                       input logic flush, input int mdly, input bit spurious);
    logic        v;
    logic [31:0] rd;
    bit          served;
    served = mem_pend && (mem_cnt == 0);
    if (served) begin
      v = 1'b1; rd = mem_word(mem_addr);
    end else if (spurious && !mem_pend) begin
      v = 1'b1; rd = $urandom;
    end else begin
      v = 1'b0; rd = $urandom;
    end
    PCSrcE = pcsrc; PCTargetE = tgt; StallD = stall; FlushD = flush;
    imem_valid = v; imem_rdata = rd;
    model_step(pcsrc, tgt, stall, flush, v, rd);
    @(posedge clk);
    #1;
    if (served) mem_pend = 0;
    else if (mem_pend) mem_cnt--;
    if (imem_req) begin
      mem_pend = 1; mem_addr = imem_addr; mem_cnt = mdly;
    end
    if (ValidD)
      $display("[TB] t=%0t fetched pc=%h instr=%h", $time, PCD, InstrD);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        pcsrc;
    logic [31:0] tgt;
    logic        stall;
    logic        flush;
    int          mdly;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pc4;
    logic        vld;
  } vec_t;

  vec_t vt[24];

  initial begin
    // basic two-word stream from RESET_PC
    vt[0]  = '{1'b0, 32'h0,   1'b0, 1'b0, 0, 1'b1, 32'h0,   32'h0,         32'h0,   32'h0,   1'b0};
    vt[1]  = '{1'b0, 32'h0,   1'b0, 1'b0, 0, 1'b0, 32'h0,   32'h1111_1111, 32'h0,   32'h4,   1'b1};
    vt[2]  = '{1'b0, 32'h0,   1'b0, 1'b0, 0, 1'b1, 32'h4,   32'h1111_1111, 32'h0,   32'h4,   1'b0};
    vt[3]  = '{1'b0, 32'h0,   1'b0, 1'b0, 0, 1'b0, 32'h4,   32'h2222_2222, 32'h4,   32'h8,   1'b1};
    // stall for three cycles as 0xAAAA0000 returns
    vt[4]  = '{1'b0, 32'h0,   1'b0, 1'b0, 0, 1'b1, 32'h8,   32'h2222_2222, 32'h4,   32'h8,   1'b0};
    vt[5]  = '{1'b0, 32'h0,   1'b1, 1'b0, 0, 1'b0, 32'h8,   32'h2222_2222, 32'h4,   32'h8,   1'b0};
    vt[6]  = '{1'b0, 32'h0,   1'b1, 1'b0, 0, 1'b0, 32'h8,   32'h2222_2222, 32'h4,   32'h8,   1'b0};
    vt[7]  = '{1'b0, 32'h0,   1'b1, 1'b0, 0, 1'b0, 32'h8,   32'h2222_2222, 32'h4,   32'h8,   1'b0};
    vt[8]  = '{1'b0, 32'h0,   1'b0, 1'b0, 0, 1'b0, 32'h8,   32'hAAAA_0000, 32'h8,   32'hC,   1'b1};
    vt[9]  = '{1'b0, 32'h0,   1'b0, 1'b0, 0, 1'b1, 32'hC,   32'hAAAA_0000, 32'h8,   32'hC,   1'b0};
    vt[10] = '{1'b0, 32'h0,   1'b0, 1'b0, 0, 1'b0, 32'hC,   32'h3333_3333, 32'hC,   32'h10,  1'b1};
    // redirect to 0x103 while waiting on a slow response
    vt[11] = '{1'b0, 32'h0,   1'b0, 1'b0, 1, 1'b1, 32'h10,  32'h3333_3333, 32'hC,   32'h10,  1'b0};
    vt[12] = '{1'b1, 32'h103, 1'b0, 1'b0, 0, 1'b0, 32'h10,  32'h3333_3333, 32'hC,   32'h10,  1'b0};
    vt[13] = '{1'b0, 32'h0,   1'b0, 1'b0, 0, 1'b0, 32'h10,  32'h3333_3333, 32'hC,   32'h10,  1'b0};
    vt[14] = '{1'b0, 32'h0,   1'b0, 1'b0, 0, 1'b1, 32'h100, 32'h3333_3333, 32'hC,   32'h10,  1'b0};
    vt[15] = '{1'b0, 32'h0,   1'b0, 1'b0, 0, 1'b0, 32'h100, 32'h4444_4444, 32'h100, 32'h104, 1'b1};
    // redirect while issuing, to the top word, then wrap
    vt[16] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 0, 1'b1, 32'h104, 32'h4444_4444, 32'h100, 32'h104, 1'b0};
    vt[17] = '{1'b0, 32'h0,   1'b0, 1'b0, 0, 1'b0, 32'h104, 32'h4444_4444, 32'h100, 32'h104, 1'b0};
    vt[18] = '{1'b0, 32'h0,   1'b0, 1'b0, 0, 1'b1, 32'hFFFF_FFFC, 32'h4444_4444, 32'h100, 32'h104, 1'b0};
    vt[19] = '{1'b0, 32'h0,   1'b0, 1'b0, 0, 1'b0, 32'hFFFF_FFFC, 32'h6666_6666, 32'hFFFF_FFFC, 32'h0, 1'b1};
    vt[20] = '{1'b0, 32'h0,   1'b0, 1'b0, 0, 1'b1, 32'h0,   32'h6666_6666, 32'hFFFF_FFFC, 32'h0, 1'b0};
    vt[21] = '{1'b0, 32'h0,   1'b0, 1'b0, 0, 1'b0, 32'h0,   32'h1111_1111, 32'h0,   32'h4,   1'b1};
    // flush together with stall
    vt[22] = '{1'b0, 32'h0,   1'b1, 1'b1, 0, 1'b1, 32'h4,   32'h0,         32'h0,   32'h4,   1'b0};
    vt[23] = '{1'b0, 32'h0,   1'b0, 1'b0, 0, 1'b0, 32'h4,   32'h2222_2222, 32'h4,   32'h8,   1'b1};

    rst = 1'b0; PCSrcE = 0; PCTargetE = 0; StallD = 0; FlushD = 0;
    imem_valid = 0; imem_rdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_instr", InstrD, 32'h0);
    chk("rst_pcd",   PCD, 32'h0);
    chk("rst_pc4",   PCPlus4D, 32'h0);
    chk("rst_vld",   {31'd0, ValidD}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 24; i++) begin
      cycle(vt[i].pcsrc, vt[i].tgt, vt[i].stall, vt[i].flush, vt[i].mdly, 1'b0);
      chk($sformatf("vec%0d_req", i),   {31'd0, imem_req}, {31'd0, vt[i].req});
      chk($sformatf("vec%0d_addr", i),  imem_addr, vt[i].addr);
      chk($sformatf("vec%0d_instr", i), InstrD, vt[i].instr);
      chk($sformatf("vec%0d_pcd", i),   PCD, vt[i].pcd);
      chk($sformatf("vec%0d_pc4", i),   PCPlus4D, vt[i].pc4);
      chk($sformatf("vec%0d_vld", i),   {31'd0, ValidD}, {31'd0, vt[i].vld});
    end

    // reset pulse while a slow fetch is outstanding
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 3, 1'b0);
    chk("pulse_pre_req",  {31'd0, imem_req}, 32'd1);
    chk("pulse_pre_addr", imem_addr, 32'h8);
    #1 rst = 1'b0;
    #1;
    chk("pulse_req",   {31'd0, imem_req}, 32'd0);
    chk("pulse_addr",  imem_addr, 32'h0);
    chk("pulse_instr", InstrD, 32'h0);
    chk("pulse_pcd",   PCD, 32'h0);
    chk("pulse_pc4",   PCPlus4D, 32'h0);
    chk("pulse_vld",   {31'd0, ValidD}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("pulse_fcnt",  FetchCount, 32'd0);
    chk("pulse_scnt",  StallCount, 32'd0);
`endif
    mem_pend = 0;
    model_reset();
    rst = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 0, 1'b0);
    chk("post_rst_req",  {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);
    check_model("post_rst");

    // randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic        pcsrc, stall, flush;
      logic [31:0] tgt;
      pcsrc = ($urandom_range(0, 9) == 0);
      tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                           : 32'($urandom);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      cycle(pcsrc, tgt, stall, flush, $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
